// File: rtl/host_loader_pkg.sv
// rtl/host_loader_pkg.sv - shared types and width helpers for the host session loader
package host_loader_pkg;

    // Session phases. FAULT is entered only on a RUN timeout and left only by start.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DUMP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Default session geometry.
    localparam int DEF_LOAD_LEN = 64;
    localparam int DEF_DUMP_LEN = 32;
    localparam int DEF_TIMEOUT  = 4095;

    // Bits needed to hold values 0..n (never less than one bit).
    function automatic int bits_for(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The byte counter serves both LOAD and DUMP; the timer only RUN.
    localparam int DEF_CNT_W = bits_for(max_of(DEF_LOAD_LEN, DEF_DUMP_LEN));
    localparam int DEF_TMR_W = bits_for(DEF_TIMEOUT);

endpackage

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - clearable RUN cycle counter flagging the timeout cycle
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : forces the count to zero (held while the core is not running)
//   en         : advances the count by one per cycle
//   expired    : high in the cycle whose count equals TIMEOUT-1
module run_watchdog
    import host_loader_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int W       = bits_for(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = (count_q == LAST);

    // Saturates at LAST so a stalled controller never sees the count wrap.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/host_loader.sv
// rtl/host_loader.sv - host session controller: load image, run core, dump result window
//
// Ports:
//   clk, reset                    : clock and synchronous active-high reset
//   start                         : begin a session (honoured in IDLE or FAULT)
//   in_valid/in_data/in_ready     : load byte stream
//   out_valid/out_data/out_ready  : dump byte stream
//   mem_sel                       : 1 = this block owns the data-memory port
//   mem_wr_en/mem_addr/mem_wr_dat : data-memory write/address port
//   mem_rd_dat                    : combinational read data for mem_addr
//   core_reset/core_done          : core hold-in-reset and completion flag
//   busy/error/session_done       : status
module host_loader
    import host_loader_pkg::*;
#(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = DEF_LOAD_LEN,
    parameter int DUMP_BASE = 64,
    parameter int DUMP_LEN  = DEF_DUMP_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          error,
    output logic          session_done
);

    localparam int CNT_W = bits_for(max_of(LOAD_LEN, DUMP_LEN));
    localparam int TMR_W = bits_for(TIMEOUT);

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] DUMP_LAST   = CNT_W'(DUMP_LEN - 1);
    localparam logic [AW-1:0]    LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0]    DUMP_BASE_A = AW'(DUMP_BASE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             session_done_q, session_done_d;
    logic             running;
    logic             tmr_expired;

    assign running = (state_q == ST_RUN);

    // Timer is held at zero outside RUN, so it always starts from 0 on entry.
    run_watchdog #(
        .TIMEOUT (TIMEOUT),
        .W       (TMR_W)
    ) u_run_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (!running),
        .en      (running),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        session_done_d = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        mem_wr_en      = 1'b0;
        mem_addr       = '0;
        mem_wr_dat     = '0;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end

            ST_LOAD: begin
                // An empty image accepts nothing and moves straight on.
                if (LOAD_LEN == 0) begin
                    state_d = ST_RUN;
                end else begin
                    in_ready   = 1'b1;
                    mem_addr   = LOAD_BASE_A + AW'(cnt_q);
                    mem_wr_dat = in_data;
                    mem_wr_en  = in_valid;
                    if (in_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LOAD_LAST) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end

            ST_RUN: begin
                // Completion takes priority over a coincident timeout.
                if (core_done) begin
                    state_d = ST_DUMP;
                    cnt_d   = '0;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_DUMP: begin
                if (DUMP_LEN == 0) begin
                    state_d        = ST_IDLE;
                    session_done_d = 1'b1;
                end else begin
                    out_valid = 1'b1;
                    mem_addr  = DUMP_BASE_A + AW'(cnt_q);
                    out_data  = mem_rd_dat;
                    if (out_ready) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == DUMP_LAST) begin
                            state_d        = ST_IDLE;
                            session_done_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            session_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            session_done_q <= session_done_d;
        end
    end

    // The core owns the memory port exactly while it is out of reset.
    assign mem_sel      = !running;
    assign core_reset   = !running;
    assign busy         = (state_q == ST_LOAD) || running || (state_q == ST_DUMP);
    assign error        = (state_q == ST_FAULT);
    assign session_done = session_done_q;

endmodule

// File: tb/tb_host_loader.sv
// tb/tb_host_loader.sv - self-checking bench for host_loader
module tb_host_loader;
    import host_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       core_done = 1'b0;
    logic       in_ready, out_valid, mem_sel, mem_wr_en, core_reset, busy, error, session_done;
    logic [7:0] out_data, mem_addr, mem_wr_dat, mem_rd_dat;

    logic       z_start = 1'b0;
    logic       z_in_valid = 1'b0;
    logic       z_core_done = 1'b0;
    logic [7:0] z_in_data = 8'h77;
    logic [7:0] z_rd = 8'h5A;
    logic       z_in_ready, z_out_valid, z_mem_sel, z_mem_wr_en, z_core_reset, z_busy, z_error, z_sd;
    logic [7:0] z_out_data, z_mem_addr, z_mem_wr_dat;

    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    host_loader #(
        .AW(8), .LOAD_BASE(8'hFE), .LOAD_LEN(4), .DUMP_BASE(0), .DUMP_LEN(2), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_dat(mem_wr_dat), .mem_rd_dat(mem_rd_dat),
        .core_reset(core_reset), .core_done(core_done),
        .busy(busy), .error(error), .session_done(session_done)
    );

    host_loader #(
        .AW(8), .LOAD_BASE(0), .LOAD_LEN(0), .DUMP_BASE(0), .DUMP_LEN(0), .TIMEOUT(3)
    ) dut_z (
        .clk(clk), .reset(reset), .start(z_start),
        .in_valid(z_in_valid), .in_data(z_in_data), .in_ready(z_in_ready),
        .out_valid(z_out_valid), .out_data(z_out_data), .out_ready(1'b1),
        .mem_sel(z_mem_sel), .mem_wr_en(z_mem_wr_en), .mem_addr(z_mem_addr),
        .mem_wr_dat(z_mem_wr_dat), .mem_rd_dat(z_rd),
        .core_reset(z_core_reset), .core_done(z_core_done),
        .busy(z_busy), .error(z_error), .session_done(z_sd)
    );

    assign mem_rd_dat = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_sel && mem_wr_en) mem[mem_addr] <= mem_wr_dat;
    end

    typedef struct {
        logic st, iv; logic [7:0] di; logic ordy, cd;
        logic e_ir, e_wr; logic [7:0] e_addr; logic e_crst, e_ov;
        logic [7:0] e_od; logic e_busy, e_err, e_sd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic iv, input logic [7:0] di,
                                input logic ordy, input logic cd, input logic ir,
                                input logic wr, input logic [7:0] addr, input logic crst,
                                input logic ov, input logic [7:0] od, input logic bsy,
                                input logic err, input logic sd);
        vec_t v;
        v.st = st; v.iv = iv; v.di = di; v.ordy = ordy; v.cd = cd;
        v.e_ir = ir; v.e_wr = wr; v.e_addr = addr; v.e_crst = crst; v.e_ov = ov;
        v.e_od = od; v.e_busy = bsy; v.e_err = err; v.e_sd = sd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cyc(input logic s, input logic v, input logic [7:0] d,
                       input logic r, input logic c);
        @(negedge clk);
        start = s; in_valid = v; in_data = d; out_ready = r; core_done = c;
        #1;
    endtask

    task automatic load4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        cyc(1'b0, 1'b1, b0, 1'b0, 1'b0);
        chk("load4 addr0", mem_addr, 8'hFE);
        cyc(1'b0, 1'b1, b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, b2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, b3, 1'b0, 1'b0);
        chk("load4 addr3", mem_addr, 8'h01);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

        // Full session: load with gaps (wrapping addresses), run 10 cycles, stalled dump.
        tbl.push_back(mk(1,0,8'h00,0,0, 0,0,8'h00,1,0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,8'h11,0,0, 1,1,8'hFE,1,0,8'h00,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'hFF,1,0,8'h00,1,0,0));
        tbl.push_back(mk(0,1,8'h22,0,0, 1,1,8'hFF,1,0,8'h00,1,0,0));
        tbl.push_back(mk(0,1,8'h33,0,0, 1,1,8'h00,1,0,8'h00,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 1,0,8'h01,1,0,8'h00,1,0,0));
        tbl.push_back(mk(0,1,8'h44,0,0, 1,1,8'h01,1,0,8'h00,1,0,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(i == 2,0,8'h00,0,0, 0,0,8'h00,0,0,8'h00,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1, 0,0,8'h00,0,0,8'h00,1,0,0));
        tbl.push_back(mk(1,0,8'h00,0,0, 0,0,8'h00,1,1,8'h33,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,1,1,8'h33,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,1,1,8'h33,1,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 0,0,8'h00,1,1,8'h33,1,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0, 0,0,8'h01,1,1,8'h44,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,1,0,8'h00,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0, 0,0,8'h00,1,0,8'h00,0,0,0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset mem_sel", mem_sel, 1);
        chk("reset core_reset", core_reset, 1);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset busy", busy, 0);
        chk("reset error", error, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].iv, tbl[i].di, tbl[i].ordy, tbl[i].cd);
            chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("row%0d mem_wr_en", i), mem_wr_en, tbl[i].e_wr);
            if (tbl[i].e_wr) chk($sformatf("row%0d mem_wr_dat", i), mem_wr_dat, tbl[i].di);
            if (!(tbl[i].e_busy && !tbl[i].e_ir && !tbl[i].e_ov))
                chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d core_reset", i), core_reset, tbl[i].e_crst);
            chk($sformatf("row%0d mem_sel", i), mem_sel, tbl[i].e_crst);
            chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("row%0d error", i), error, tbl[i].e_err);
            chk($sformatf("row%0d session_done", i), session_done, tbl[i].e_sd);
        end
        chk("mem FE", mem[8'hFE], 8'h11);
        chk("mem FF", mem[8'hFF], 8'h22);
        chk("mem 00", mem[8'h00], 8'h33);
        chk("mem 01", mem[8'h01], 8'h44);
        chk("mem 02 untouched", mem[8'h02], 8'hA7);

        // Timeout: exactly 20 RUN cycles, then FAULT.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        load4(8'h11, 8'h22, 8'h33, 8'h44);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            if (core_reset) break;
            n++;
        end
        chk("timeout run cycles", n, 20);
        chk("fault error", error, 1);
        chk("fault core_reset", core_reset, 1);
        chk("fault busy", busy, 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fault holds error", error, 1);
        cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("restart error", error, 0);
        chk("restart in_ready", in_ready, 1);
        chk("restart addr", mem_addr, 8'hFE);
        cyc(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);

        // Reset mid-LOAD after two bytes.
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset in_ready", in_ready, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset mem_wr_en", mem_wr_en, 0);
        chk("midreset mem_addr", mem_addr, 0);
        chk("midreset core_reset", core_reset, 1);
        chk("midreset busy", busy, 0);
        chk("midreset session_done", session_done, 0);
        chk("midreset mem FE", mem[8'hFE], 8'h55);
        chk("midreset mem FF", mem[8'hFF], 8'h66);
        chk("midreset mem 00", mem[8'h00], 8'h33);

        // Fresh session from LOAD_BASE; done coincides with the timeout cycle.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        load4(8'h11, 8'h22, 8'h33, 8'h44);
        n = 0;
        for (int i = 0; i < 19; i++) begin
            cyc(i == 5, 1'b0, 8'h00, 1'b0, 1'b0);
            if (!core_reset) n++;
        end
        chk("coincide pre-run cycles", n, 19);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("coincide still run", core_reset, 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("coincide dump valid", out_valid, 1);
        chk("coincide no error", error, 0);
        chk("coincide data0", out_data, 8'h33);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("start in dump ignored", out_data, 8'h33);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("coincide data1", out_data, 8'h44);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("coincide session_done", session_done, 1);
        chk("coincide idle busy", busy, 0);

        // Zero-length load and dump instance.
        @(negedge clk);
        z_start = 1'b1;
        #1;
        chk("z idle busy", z_busy, 0);
        @(negedge clk);
        z_start = 1'b0; z_in_valid = 1'b1;
        #1;
        chk("z load no write", z_mem_wr_en, 0);
        chk("z load busy", z_busy, 1);
        @(negedge clk);
        z_in_valid = 1'b0; z_core_done = 1'b1;
        #1;
        chk("z run core_reset", z_core_reset, 0);
        @(negedge clk);
        z_core_done = 1'b0;
        #1;
        chk("z dump out_valid", z_out_valid, 0);
        chk("z dump core_reset", z_core_reset, 1);
        chk("z dump busy", z_busy, 1);
        @(negedge clk);
        #1;
        chk("z session_done", z_sd, 1);
        chk("z idle", z_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
